// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
// ---------------------------------------------------------------------------
// Error-characterisation stage for an 8x8 approximate multiplier. Each
// accepted sample (a, b, prod_approx) is compared against the exact product
// a*b. Over a window of SAMPLES products the block accumulates:
//   - err_cnt : number of samples with a nonzero error distance
//   - sum_ed  : sum of error distances (saturating at 2^SUM_W-1)
//   - max_ed  : largest error distance seen
// The error distance is ED = |a*b - prod_approx|.
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   start          one-cycle pulse; honoured only in IDLE/DONE, clears stats
//   in_valid       a/b/prod_approx valid this cycle
//   in_ready       block accepts a sample this cycle
//   a, b           unsigned 8-bit operands
//   prod_approx    approximate product from the multiplier under test
//   busy           window open or pipeline draining
//   done           statistics final; held until the next start
//   sample_cnt     samples accepted in the current window
//   err_cnt        samples with nonzero error distance
//   sum_ed         saturating sum of error distances
//   max_ed         largest error distance in the window
//   state_dbg      current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready does not depend on in_valid. The source may hold or
// drop in_valid freely; gaps simply pass as bubbles through the pipeline.
// ---------------------------------------------------------------------------
module approx_mul_err_monitor #(
  parameter int SAMPLES = 256,
  parameter int SUM_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      prod_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             clear_stats;

  logic             s1_valid_q;
  logic [15:0]      s1_exact_q;
  logic [15:0]      s1_approx_q;
  logic             s2_valid_q;
  logic [15:0]      s2_ed_q;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic [15:0]      max_ed_q, max_ed_d;

  logic [15:0]      exact_prod;
  logic [15:0]      ed_val;
  logic [SUM_W:0]   sum_wide;

  // Zero-extend before multiplying so the full 16-bit product is kept.
  assign exact_prod = {8'd0, a} * {8'd0, b};

  assign ed_val = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                              : (s1_approx_q - s1_exact_q);

  // One extra bit catches the carry; a carry means the sum saturates. Once at
  // all-ones any nonzero ED carries again, so saturation is sticky.
  assign sum_wide = (SUM_W+1)'(sum_ed_q) + (SUM_W+1)'(s2_ed_q);

  // FSM: next state and per-state outputs.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    clear_stats = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          clear_stats = 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = (sample_cnt_q < CNT_W'(SAMPLES));
        accept   = in_valid & in_ready;
        if (accept && (sample_cnt_q == CNT_W'(SAMPLES - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // No accepts happen here, so S1 empty now means both stages are
        // empty after this edge (S2 retires its last sample on this edge).
        if (!s1_valid_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d     = RUN;
          clear_stats = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics next-state.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    if (clear_stats) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sum_ed_d     = '0;
      max_ed_d     = '0;
    end else begin
      if (accept) begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end
      if (s2_valid_q) begin
        if (s2_ed_q != 16'd0) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        sum_ed_d = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
        if (s2_ed_q > max_ed_q) begin
          max_ed_d = s2_ed_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_valid_q   <= 1'b0;
      s1_exact_q   <= '0;
      s1_approx_q  <= '0;
      s2_valid_q   <= 1'b0;
      s2_ed_q      <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
    end else begin
      state_q      <= state_d;
      s1_valid_q   <= accept;
      s1_exact_q   <= exact_prod;
      s1_approx_q  <= prod_approx;
      s2_valid_q   <= s1_valid_q;
      s2_ed_q      <= ed_val;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Testbench for approx_mul_err_monitor. Two instances: u_dut4 (SAMPLES=4,
// SUM_W=32) and u_dut3 (SAMPLES=3, SUM_W=16, for saturation). Inputs are
// shared; only the instance that was started is in RUN and takes samples.
// Window results are hand-computed and pushed when a window is issued; a
// monitor per instance pops and compares when done rises.
module tb_approx_mul_err_monitor;

  logic        clk;
  logic        rst;
  logic        start4;
  logic        start3;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod;

  logic        in_ready4, busy4, done4;
  logic [15:0] sample_cnt4, err_cnt4, max_ed4;
  logic [31:0] sum_ed4;
  logic [1:0]  state4;

  logic        in_ready3, busy3, done3;
  logic [15:0] sample_cnt3, err_cnt3, max_ed3;
  logic [15:0] sum_ed3;
  logic [1:0]  state3;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected window result: {sample_cnt[16], err_cnt[16], sum_ed[32], max_ed[16]}
  logic [79:0] exp_q4[$];
  logic [79:0] exp_q3[$];

  approx_mul_err_monitor #(.SAMPLES(4), .SUM_W(32), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .prod_approx(prod), .busy(busy4), .done(done4),
    .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .sum_ed(sum_ed4), .max_ed(max_ed4),
    .state_dbg(state4)
  );

  approx_mul_err_monitor #(.SAMPLES(3), .SUM_W(16), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .in_valid(in_valid), .in_ready(in_ready3),
    .a(a), .b(b), .prod_approx(prod), .busy(busy3), .done(done3),
    .sample_cnt(sample_cnt3), .err_cnt(err_cnt3), .sum_ed(sum_ed3), .max_ed(max_ed3),
    .state_dbg(state3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sel_ready(input int sel);
    return (sel == 4) ? in_ready4 : in_ready3;
  endfunction

  function automatic logic sel_busy(input int sel);
    return (sel == 4) ? busy4 : busy3;
  endfunction

  function automatic logic sel_done(input int sel);
    return (sel == 4) ? done4 : done3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 4) start4 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start3 = 1'b0;
  endtask

  // Present one sample and hold it until it is taken on a rising edge.
  task automatic feed(input int sel, input logic [7:0] va, input logic [7:0] vb,
                      input logic [15:0] vp);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = va;
    b = vb;
    prod = vp;
    while (sel_ready(sel) !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (g >= 10) begin
      n_cmp++;
      n_fail++;
      $display("FAIL feed_ready_timeout: in_ready stayed %0d, expected 1", sel_ready(sel));
    end
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called right after the edge of the last accept (edge k). Keeps junk on
  // the input with in_valid=1 to show it is ignored, and checks that done
  // rises exactly after edge k+2.
  task automatic finish_window(input int sel);
    @(negedge clk);
    check("ready_drop_after_last", sel_ready(sel), 0);
    check("busy_in_drain", sel_busy(sel), 1);
    check("no_done_k0", sel_done(sel), 0);
    in_valid = 1'b1;
    a = 8'd255;
    b = 8'd255;
    prod = 16'd0;
    @(negedge clk);
    check("no_done_k1", sel_done(sel), 0);
    @(negedge clk);
    check("done_at_k2", sel_done(sel), 1);
    check("busy_off_done", sel_busy(sel), 0);
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  initial begin
    logic        prev;
    logic [79:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done4 && !prev) begin
        if (exp_q4.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL dut4_unexpected_done: got done=1 expected no window pending");
        end else begin
          e = exp_q4.pop_front();
          check("dut4_sample_cnt", 64'(sample_cnt4), 64'(e[79:64]));
          check("dut4_err_cnt",    64'(err_cnt4),    64'(e[63:48]));
          check("dut4_sum_ed",     64'(sum_ed4),     64'(e[47:16]));
          check("dut4_max_ed",     64'(max_ed4),     64'(e[15:0]));
        end
      end
      prev = done4;
    end
  end

  initial begin
    logic        prev;
    logic [79:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done3 && !prev) begin
        if (exp_q3.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL dut3_unexpected_done: got done=1 expected no window pending");
        end else begin
          e = exp_q3.pop_front();
          check("dut3_sample_cnt", 64'(sample_cnt3), 64'(e[79:64]));
          check("dut3_err_cnt",    64'(err_cnt3),    64'(e[63:48]));
          check("dut3_sum_ed",     64'(sum_ed3),     64'(e[47:16]));
          check("dut3_max_ed",     64'(max_ed3),     64'(e[15:0]));
        end
      end
      prev = done3;
    end
  end

  // ---------------- stimulus ----------------
  logic        t3_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0]  t3_a [7] = '{8'd2, 8'd255, 8'd255, 8'd4, 8'd100, 8'd255, 8'd5};
  logic [7:0]  t3_b [7] = '{8'd3, 8'd255, 8'd255, 8'd4, 8'd100, 8'd255, 8'd5};
  logic [15:0] t3_p [7] = '{16'd7, 16'd0, 16'd0, 16'd10, 16'd9990, 16'd0, 16'd30};

  initial begin
    rst = 1'b1;
    start4 = 1'b0;
    start3 = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    prod = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_sample_cnt", 64'(sample_cnt4), 0);
    check("rst_err_cnt", 64'(err_cnt4), 0);
    check("rst_sum_ed", 64'(sum_ed4), 0);
    check("rst_max_ed", 64'(max_ed4), 0);
    check("rst_state", 64'(state4), 0);
    check("rst_dut3_busy", busy3, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready_after_rst", in_ready4, 0);

    // Window 1: all exact
    pulse_start(4);
    check("w1_busy", busy4, 1);
    check("w1_in_ready", in_ready4, 1);
    exp_q4.push_back({16'd4, 16'd0, 32'd0, 16'd0});
    feed(4, 8'd3, 8'd5, 16'd15);
    feed(4, 8'd255, 8'd255, 16'd65025);
    feed(4, 8'd0, 8'd9, 16'd0);
    feed(4, 8'd16, 8'd16, 16'd256);
    finish_window(4);

    // Window 2: restart from DONE, then a start pulse during RUN
    pulse_start(4);
    check("restart_done_clr", done4, 0);
    check("restart_busy", busy4, 1);
    check("restart_sample_cnt", 64'(sample_cnt4), 0);
    check("restart_err_cnt", 64'(err_cnt4), 0);
    check("restart_sum_ed", 64'(sum_ed4), 0);
    check("restart_max_ed", 64'(max_ed4), 0);
    exp_q4.push_back({16'd4, 16'd3, 32'd15, 16'd10});
    feed(4, 8'd10, 8'd10, 16'd96);
    feed(4, 8'd7, 8'd7, 16'd49);
    go_idle();
    pulse_start(4);
    @(negedge clk);
    check("run_start_sample_cnt", 64'(sample_cnt4), 2);
    check("run_start_err_cnt", 64'(err_cnt4), 1);
    check("run_start_sum_ed", 64'(sum_ed4), 4);
    check("run_start_max_ed", 64'(max_ed4), 4);
    feed(4, 8'd200, 8'd3, 16'd610);
    feed(4, 8'd1, 8'd1, 16'd0);
    finish_window(4);

    // Window 3: gapped in_valid 1,0,0,1,1,0,1 then junk that must be ignored
    pulse_start(4);
    exp_q4.push_back({16'd4, 16'd4, 32'd22, 16'd10});
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = t3_v[i];
      a = t3_a[i];
      b = t3_b[i];
      prod = t3_p[i];
      @(posedge clk);
    end
    finish_window(4);
    check("w3_sample_cnt_final", 64'(sample_cnt4), 4);

    // Window 4 on the SUM_W=16 instance: saturation
    pulse_start(3);
    exp_q3.push_back({16'd3, 16'd3, 32'd65535, 16'd65025});
    feed(3, 8'd255, 8'd255, 16'd0);
    feed(3, 8'd255, 8'd255, 16'd0);
    feed(3, 8'd255, 8'd255, 16'd0);
    finish_window(3);

    // Window 5: async reset mid-window, then a clean window
    pulse_start(4);
    feed(4, 8'd9, 8'd9, 16'd80);
    feed(4, 8'd9, 8'd9, 16'd80);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready4, 0);
    check("arst_busy", busy4, 0);
    check("arst_done", done4, 0);
    check("arst_sample_cnt", 64'(sample_cnt4), 0);
    check("arst_err_cnt", 64'(err_cnt4), 0);
    check("arst_sum_ed", 64'(sum_ed4), 0);
    check("arst_max_ed", 64'(max_ed4), 0);
    check("arst_state", 64'(state4), 0);
    check("arst_dut3_done", done3, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(4);
    exp_q4.push_back({16'd4, 16'd0, 32'd0, 16'd0});
    feed(4, 8'd6, 8'd7, 16'd42);
    feed(4, 8'd12, 8'd12, 16'd144);
    feed(4, 8'd0, 8'd0, 16'd0);
    feed(4, 8'd128, 8'd2, 16'd256);
    finish_window(4);

    // Stats hold while done=1
    repeat (3) @(negedge clk);
    check("hold_done", done4, 1);
    check("hold_sample_cnt", 64'(sample_cnt4), 4);
    check("dut4_queue_empty", 64'(exp_q4.size()), 0);
    check("dut3_queue_empty", 64'(exp_q3.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
